// File: rtl/iob_vexriscv_dbus_bridge_if.sv
// Signal bundle for the dBus-to-IOb bridge: VexRiscv simple dBus on the CPU side,
// IOb native request/response on the system side.
interface iob_vexriscv_dbus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                dbus_cmd_valid;
    logic                dbus_cmd_ready;
    logic                dbus_cmd_wr;
    logic [ADDR_W-1:0]   dbus_cmd_address;
    logic [DATA_W-1:0]   dbus_cmd_data;
    logic [1:0]          dbus_cmd_size;
    logic                dbus_rsp_ready;
    logic                dbus_rsp_error;
    logic [DATA_W-1:0]   dbus_rsp_data;
    logic                iob_valid;
    logic [ADDR_W-1:0]   iob_address;
    logic [DATA_W-1:0]   iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic                iob_ready;
    logic [DATA_W-1:0]   iob_rdata;

    // master: the bridge, which masters the IOb bus and serves the CPU dBus
    modport master (
        input  dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
        output dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_error, dbus_rsp_data,
        output iob_valid, iob_address, iob_wdata, iob_wstrb,
        input  iob_ready, iob_rdata
    );

    // slave: the surrounding CPU and IOb slave seen from outside the bridge
    modport slave (
        output dbus_cmd_valid, dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size,
        input  dbus_cmd_ready, dbus_rsp_ready, dbus_rsp_error, dbus_rsp_data,
        input  iob_valid, iob_address, iob_wdata, iob_wstrb,
        output iob_ready, iob_rdata
    );
endinterface

// File: rtl/iob_vexriscv_dbus_bridge.sv
// Registered VexRiscv dBus to IOb bridge: one outstanding access, local rejection of
// misaligned/illegal commands, and a watchdog bounding every IOb access.
module iob_vexriscv_dbus_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                TIMEOUT_W = 8,
    parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                        clk,
    input  logic                        rst,
    iob_vexriscv_dbus_bridge_if.master  bus,
    output logic [7:0]                  err_count
);
    localparam int STRB_W = DATA_W / 8;
    // Last REQ cycle index before the watchdog gives up (2^TIMEOUT_W-1 cycles in total)
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

    state_t               state_q, state_d;
    logic                 wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    wstrb_q, wstrb_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [7:0]           err_q, err_d;
    logic                 err_inc;

    logic                 cmd_ready, iob_valid, rsp_ready, rsp_error;
    logic [DATA_W-1:0]    rsp_data;

    logic                 cmd_illegal;
    logic [STRB_W-1:0]    base_mask, cmd_mask;
    logic [DATA_W-1:0]    wdata_rep;

    assign cmd_illegal = (bus.dbus_cmd_size == 2'd3)
                      || (bus.dbus_cmd_size == 2'd2 && bus.dbus_cmd_address[1:0] != 2'b00)
                      || (bus.dbus_cmd_size == 2'd1 && bus.dbus_cmd_address[0]);

    always_comb begin
        case (bus.dbus_cmd_size)
            2'd0:    base_mask = STRB_W'(4'h1);
            2'd1:    base_mask = STRB_W'(4'h3);
            default: base_mask = STRB_W'(4'hF);
        endcase
    end

    assign cmd_mask = base_mask << bus.dbus_cmd_address[1:0];

    // Each lane carries the store data replicated so the strobed lane always holds it
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign wdata_rep[gi*8 +: 8] =
                (bus.dbus_cmd_size == 2'd0) ? bus.dbus_cmd_data[7:0] :
                (bus.dbus_cmd_size == 2'd1) ? bus.dbus_cmd_data[(gi%2)*8 +: 8] :
                                              bus.dbus_cmd_data[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        tmo_d     = tmo_q;
        err_inc   = 1'b0;
        cmd_ready = 1'b0;
        iob_valid = 1'b0;
        rsp_ready = 1'b0;
        rsp_error = 1'b0;
        rsp_data  = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.dbus_cmd_valid) begin
                    wr_d    = bus.dbus_cmd_wr;
                    addr_d  = {bus.dbus_cmd_address[ADDR_W-1:2], 2'b00};
                    wdata_d = wdata_rep;
                    wstrb_d = bus.dbus_cmd_wr ? cmd_mask : '0;
                    tmo_d   = '0;
                    state_d = cmd_illegal ? ERR : REQ;
                end
            end
            REQ: begin
                iob_valid = 1'b1;
                // ready takes priority over a watchdog expiring in the same cycle
                if (bus.iob_ready) begin
                    rdata_d = bus.iob_rdata;
                    state_d = wr_q ? IDLE : RSP;
                end else if (tmo_q == TMO_LAST) begin
                    err_inc = wr_q;
                    state_d = wr_q ? IDLE : ERR;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_W'(1);
                end
            end
            RSP: begin
                rsp_ready = 1'b1;
                rsp_data  = rdata_q;
                state_d   = IDLE;
            end
            ERR: begin
                rsp_ready = !wr_q;
                rsp_error = !wr_q;
                rsp_data  = wr_q ? '0 : ERR_DATA;
                err_inc   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    assign bus.dbus_cmd_ready = cmd_ready;
    assign bus.dbus_rsp_ready = rsp_ready;
    assign bus.dbus_rsp_error = rsp_error;
    assign bus.dbus_rsp_data  = rsp_data;
    assign bus.iob_valid      = iob_valid;
    assign bus.iob_address    = addr_q;
    assign bus.iob_wdata      = wdata_q;
    assign bus.iob_wstrb      = wstrb_q;
    assign err_count          = err_q;
endmodule

// File: tb/tb_iob_vexriscv_dbus_bridge.sv
// Randomised and directed bench for the dBus-to-IOb bridge, checked against a
// transaction-level model of the expected bus activity, responses and timing.
module tb_iob_vexriscv_dbus_bridge;
    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          TIMEOUT_W = 4;
    localparam int          TMO_LIMIT = (1 << TIMEOUT_W) - 1;
    localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] err_count;

    iob_vexriscv_dbus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    iob_vexriscv_dbus_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_W(TIMEOUT_W), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk(clk), .rst(rst_n), .bus(bus), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expectations for the transaction currently in flight
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    logic        exp_rsp_err;
    int          model_err = 0;
    int          valid_seen = 0, rsp_seen = 0, last_span = 0;
    logic [31:0] last_iob_addr = 0, last_iob_wdata = 0, last_rsp_data = 0;
    logic [3:0]  last_iob_strb = 0;
    logic        last_rsp_err = 0;

    // Slave behaviour knobs
    int          slave_wait = 0;
    bit          force_rdata_en = 0;
    logic [31:0] force_rdata = 0;
    logic [31:0] slave_cap_rdata = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Spec-level model: sizes in bytes, lane offset arithmetic, byte-by-byte replication
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [1:0] size, output logic legal,
                                  output logic [31:0] a, output logic [31:0] wd, output logic [3:0] st);
        int nb;
        int off;
        nb    = 1 << int'(size);
        off   = int'(addr[1:0]);
        legal = (size != 2'd3) && ((off % nb) == 0);
        a     = addr - 32'(off);
        wd    = 32'h0;
        for (int i = 0; i < 4; i++)
            wd = wd | (((data >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        st = wr ? 4'(((1 << nb) - 1) << off) : 4'h0;
    endfunction

    // IOb slave: raises ready on the slave_wait-th cycle of iob_valid (0 = zero-wait)
    initial begin
        int vcnt;
        vcnt = 0;
        bus.iob_ready = 1'b0;
        bus.iob_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.iob_rdata = $urandom;
            if (!bus.iob_valid) begin
                vcnt = 0;
                bus.iob_ready = 1'b0;
            end else begin
                bus.iob_ready = (vcnt == slave_wait);
                if (bus.iob_ready) begin
                    if (force_rdata_en) bus.iob_rdata = force_rdata;
                    slave_cap_rdata = bus.iob_rdata;
                end
                vcnt++;
            end
        end
    end

    // Per-cycle compare of DUT outputs against current expectations
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.iob_valid) begin
                    valid_seen++;
                    check("iob_address", bus.iob_address, exp_addr);
                    check("iob_wdata", bus.iob_wdata, exp_wdata);
                    check("iob_wstrb", 32'(bus.iob_wstrb), 32'(exp_strb));
                    check("cmd_ready_in_req", 32'(bus.dbus_cmd_ready), 32'd0);
                    last_iob_addr  = bus.iob_address;
                    last_iob_wdata = bus.iob_wdata;
                    last_iob_strb  = bus.iob_wstrb;
                end
                if (bus.dbus_rsp_ready) begin
                    rsp_seen++;
                    check("rsp_error", 32'(bus.dbus_rsp_error), 32'(exp_rsp_err));
                    check("rsp_data", bus.dbus_rsp_data, exp_rsp_err ? ERR_DATA : slave_cap_rdata);
                    check("cmd_ready_in_rsp", 32'(bus.dbus_cmd_ready), 32'd0);
                    last_rsp_data = bus.dbus_rsp_data;
                    last_rsp_err  = bus.dbus_rsp_error;
                end else begin
                    check("rsp_idle_zero", bus.dbus_rsp_data | 32'(bus.dbus_rsp_error), 32'd0);
                end
            end
        end
    end

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] size, input int wait_n, input bit keep);
        logic        legal;
        logic [31:0] m_addr, m_wdata;
        logic [3:0]  m_strb;
        bit          tmo;
        int          v_exp, span_exp, rsp_exp, n;
        model(wr, addr, data, size, legal, m_addr, m_wdata, m_strb);
        tmo      = legal && (wait_n >= TMO_LIMIT);
        v_exp    = !legal ? 0 : (tmo ? TMO_LIMIT : wait_n + 1);
        span_exp = !legal ? 3 : (wr ? v_exp + 2 : v_exp + 3);
        rsp_exp  = wr ? 0 : 1;
        slave_wait = wait_n;
        bus.dbus_cmd_wr      = wr;
        bus.dbus_cmd_address = addr;
        bus.dbus_cmd_data    = data;
        bus.dbus_cmd_size    = size;
        bus.dbus_cmd_valid   = 1'b1;
        n = 0;
        while (!bus.dbus_cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(bus.dbus_cmd_ready), 32'd1);
        @(posedge clk);
        exp_addr    = m_addr;
        exp_wdata   = m_wdata;
        exp_strb    = m_strb;
        exp_rsp_err = !legal || tmo;
        valid_seen  = 0;
        rsp_seen    = 0;
        if ((!legal || tmo) && model_err < 255) model_err++;
        #1;
        if (!keep) bus.dbus_cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dbus_cmd_ready && n < 64);
        last_span = n + 1;
        check("span", 32'(n + 1), 32'(span_exp));
        check("valid_cycles", 32'(valid_seen), 32'(v_exp));
        check("rsp_pulses", 32'(rsp_seen), 32'(rsp_exp));
        check("err_count", 32'(err_count), 32'(model_err));
        $display("txn wr=%0d addr=%h data=%h size=%0d wait=%0d legal=%0d span=%0d valid=%0d rsp=%0d err_count=%0d",
                 wr, addr, data, size, wait_n, legal, n + 1, valid_seen, rsp_seen, err_count);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        logic        m_legal;
        logic [31:0] m_a, m_wd;
        logic [3:0]  m_st;
        int          r, w;
        logic [1:0]  sz;

        bus.dbus_cmd_valid   = 1'b0;
        bus.dbus_cmd_wr      = 1'b0;
        bus.dbus_cmd_address = 32'h0;
        bus.dbus_cmd_data    = 32'h0;
        bus.dbus_cmd_size    = 2'd0;

        // Pin the model with hand-computed cases
        model(1'b1, 32'h203, 32'hAB, 2'd0, m_legal, m_a, m_wd, m_st);
        check("model_byte_addr", m_a, 32'h200);
        check("model_byte_strb", 32'(m_st), 32'h8);
        check("model_byte_wdata", m_wd, 32'hABABABAB);
        model(1'b0, 32'h201, 32'h0, 2'd1, m_legal, m_a, m_wd, m_st);
        check("model_half_misaligned", 32'(m_legal), 32'd0);

        #2 rst_n = 1'b0;
        #10;
        check("reset_cmd_ready", 32'(bus.dbus_cmd_ready), 32'd1);
        check("reset_iob_valid", 32'(bus.iob_valid), 32'd0);
        check("reset_rsp", 32'(bus.dbus_rsp_ready) | 32'(bus.dbus_rsp_error) | bus.dbus_rsp_data, 32'd0);
        check("reset_iob_bus", bus.iob_address | bus.iob_wdata | 32'(bus.iob_wstrb), 32'd0);
        check("reset_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        force_rdata_en = 1;
        force_rdata    = 32'h12345678;
        run_txn(1'b0, 32'h100, 32'h0, 2'd2, 2, 0);
        check("word_load_data", last_rsp_data, 32'h12345678);
        check("word_load_err", 32'(last_rsp_err), 32'd0);
        check("word_load_strb", 32'(last_iob_strb), 32'd0);
        force_rdata_en = 0;

        run_txn(1'b1, 32'h203, 32'h000000AB, 2'd0, 1, 0);
        check("byte_store_addr", last_iob_addr, 32'h200);
        check("byte_store_strb", 32'(last_iob_strb), 32'h8);
        check("byte_store_wdata", last_iob_wdata, 32'hABABABAB);

        run_txn(1'b1, 32'h202, 32'h0000BEEF, 2'd1, 0, 0);
        check("half_store_strb", 32'(last_iob_strb), 32'hC);
        check("half_store_wdata", last_iob_wdata, 32'hBEEFBEEF);

        run_txn(1'b0, 32'h201, 32'h0, 2'd1, 0, 0);
        check("illegal_half_data", last_rsp_data, 32'hDEADBEEF);
        check("illegal_half_err", 32'(last_rsp_err), 32'd1);
        check("illegal_half_count", 32'(err_count), 32'd1);

        run_txn(1'b0, 32'h300, 32'h0, 2'd2, 1000, 0);
        check("timeout_valid_cycles", 32'(valid_seen), 32'd15);
        check("timeout_rsp_data", last_rsp_data, 32'hDEADBEEF);
        check("timeout_cmd_ready", 32'(bus.dbus_cmd_ready), 32'd1);

        run_txn(1'b0, 32'h304, 32'h0, 2'd2, 14, 0);
        run_txn(1'b1, 32'h308, 32'h55AA55AA, 2'd2, 20, 0);
        run_txn(1'b1, 32'h30C, 32'h0, 2'd3, 0, 0);

        run_txn(1'b0, 32'h400, 32'h0, 2'd2, 0, 1);
        check("b2b_span_inclusive", 32'(last_span), 32'd4);
        run_txn(1'b0, 32'h404, 32'h0, 2'd2, 0, 0);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      w = $urandom_range(0, 3);
            else if (r == 6) w = 14;
            else if (r == 7) w = 15;
            else if (r == 8) w = 40;
            else             w = 0;
            sz = 2'($urandom_range(0, 3));
            run_txn(1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 255)), $urandom,
                    sz, w, (i != 59) && ($urandom_range(0, 1) == 1));
        end

        // Reset in the middle of a pending load abandons it silently
        slave_wait           = 1000;
        bus.dbus_cmd_wr      = 1'b0;
        bus.dbus_cmd_address = 32'h500;
        bus.dbus_cmd_size    = 2'd2;
        bus.dbus_cmd_valid   = 1'b1;
        @(posedge clk);
        exp_addr    = 32'h500;
        exp_wdata   = bus.iob_wdata;
        exp_strb    = 4'h0;
        exp_rsp_err = 1'b1;
        #1;
        exp_wdata = bus.iob_wdata;
        bus.dbus_cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.iob_valid), 32'd0);
        check("async_rst_cmd_ready", 32'(bus.dbus_cmd_ready), 32'd1);
        check("async_rst_err_count", 32'(err_count), 32'd0);
        model_err  = 0;
        valid_seen = 0;
        rsp_seen   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_rsp", 32'(rsp_seen), 32'd0);
        check("post_rst_valid", 32'(valid_seen), 32'd0);
        check("post_rst_cmd_ready", 32'(bus.dbus_cmd_ready), 32'd1);

        run_txn(1'b0, 32'h600, 32'h0, 2'd0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/iob_vexriscv_dbus_bridge.md
Name: iob_vexriscv_dbus_bridge

Overview:
- Registered bridge between the VexRiscv simple dBus (cmd/rsp) and the IOb native request/response bus (valid/address/wdata/wstrb → ready/rdata).
- Sits directly downstream of the CPU wrapper's data port and feeds the system interconnect.
- Allows one outstanding transaction and holds the request until the IOb slave responds.
- Generates byte strobes, rejects misaligned or illegal accesses locally, and bounds every access with a watchdog timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (fixed at 32; strobe width DATA_W/8).
- TIMEOUT_W, 8, watchdog counter width; timeout fires after 2^TIMEOUT_W-1 cycles waiting for ready.
- ERR_DATA, 32'hDEADBEEF, read data returned on an error response.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- dbus_cmd_valid  in  1  CPU request valid.
- dbus_cmd_ready  out  1  bridge accepts request.
- dbus_cmd_wr  in  1  1 = store, 0 = load.
- dbus_cmd_address  in  ADDR_W  byte address.
- dbus_cmd_data  in  DATA_W  store data, LSB-aligned.
- dbus_cmd_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- dbus_rsp_ready  out  1  load response valid, single-cycle pulse.
- dbus_rsp_error  out  1  qualifies dbus_rsp_ready; access faulted.
- dbus_rsp_data  out  DATA_W  raw load word.
- iob_valid  out  1  IOb request valid.
- iob_address  out  ADDR_W  IOb address, word-aligned (bits [1:0] forced 0).
- iob_wdata  out  DATA_W  IOb write data, lane-replicated.
- iob_wstrb  out  DATA_W/8  byte strobes; 0 for reads.
- iob_ready  in  1  IOb response/acknowledge.
- iob_rdata  in  DATA_W  IOb read data, valid when iob_ready.
- err_count  out  8  saturating count of faulted accesses.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0, except dbus_cmd_ready=1.
  - err_count=0; timeout counter cleared.
  - A reset during an access abandons it; no response is issued.
- States: IDLE, REQ, RSP, ERR.
- IDLE:
  - dbus_cmd_ready=1. A command is accepted when dbus_cmd_valid=1.
  - Illegal command (size=3, size=2 with addr[1:0]≠0, or size=1 with addr[0]=1) → ERR. No IOb access is made.
  - Legal command → REQ. The request is registered.
- Strobe generation: base mask is 4'h1 (byte), 4'h3 (half) or 4'hF (word), shifted left by addr[1:0]. iob_wstrb = mask for stores, 0 for loads.
- Write data replication:
  - byte: {4{d[7:0]}}
  - half: {2{d[15:0]}}
  - word: d
- REQ:
  - iob_valid=1; address, wdata and wstrb are held stable; dbus_cmd_ready=0.
  - Minimum latency: command accepted in cycle 0 → iob_valid=1 in cycle 1.
  - iob_ready=1, load → capture iob_rdata → RSP.
  - iob_ready=1, store → IDLE. Stores produce no CPU response.
  - iob_ready=1 in the same cycle the timeout expires → ready wins, normal completion.
  - Timeout counter increments each REQ cycle without ready. At 2^TIMEOUT_W-1 → iob_valid drops; load → ERR, store → IDLE with err_count increment.
  - iob_valid deasserts in the cycle after iob_ready is sampled.
- RSP: one cycle with dbus_rsp_ready=1, dbus_rsp_error=0, dbus_rsp_data=captured word; then IDLE. dbus_cmd_ready returns to 1 in the following cycle.
- ERR:
  - Load: one cycle with dbus_rsp_ready=1, dbus_rsp_error=1, dbus_rsp_data=ERR_DATA.
  - Store: no response pulse.
  - Both: err_count += 1 (saturating at 255); → IDLE.
- Throughput: a zero-wait load takes 4 cycles from accept to next accept (accept, REQ, RSP, IDLE). A zero-wait store takes 3.
- dbus_rsp_* outputs are 0 whenever dbus_rsp_ready=0.

Test Plan:
- Word load at 0x100; slave ready 2 cycles after valid with rdata 0x12345678 → iob_wstrb=0; dbus_rsp_ready pulses once with data 0x12345678, error=0.
- Byte store, data 0xAB, addr 0x203 → iob_address=0x200, iob_wstrb=4'h8, iob_wdata=0xABABABAB; no dbus_rsp_ready pulse.
- Half store at 0x202 with data 0xBEEF → wstrb=4'hC, wdata=0xBEEFBEEF. Half load at 0x201 → no iob_valid; rsp error=1, data 0xDEADBEEF; err_count=1.
- Load with slave never ready, TIMEOUT_W=4 → iob_valid high exactly 15 cycles, then error response with 0xDEADBEEF; cmd_ready back to 1 after it.
- Assert rst low mid-REQ → iob_valid=0 immediately (async), no rsp pulse after release, cmd_ready=1.
- Back-to-back loads with dbus_cmd_valid held → second accept exactly 4 cycles after the first with zero-wait slave; cmd_ready low throughout REQ/RSP.
